conv_mac_18: RTL and testbench

Downstream consumer of the layer-18 weight streamer. It pops one coefficient from the weight FIFO and one activation from the input FIFO per cycle, multiplies them in a registered pipeline and accumulates KERN_SIZE products. It then rescales the sum and pushes one output sample into the next FIFO. All three streams use the ap_fifo handshake: FWFT read side, full_n write side.

---
 rtl/conv_mac_18.sv | 131 +++++++++++++
 tb/tb_conv_mac_18.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_18.sv
`default_nettype none
// ============================================================================
// Module   : conv_mac_18
// Brief    : Layer-18 multiply-accumulate consumer. Pops weight/activation
//            pairs, accumulates KERN_SIZE products, then rescales the sum and
//            pushes one sample. Define MAC_SAT_EN for a saturating output
//            instead of a truncating one.
// Revision : 1.0 - initial release
// ============================================================================
module conv_mac_18 #(
    parameter int COEFF_WIDTH = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int KERN_SIZE   = 9,
    parameter int ACC_WIDTH   = 40,
    parameter int OUT_SHIFT   = 8,
    parameter int OUT_WIDTH   = 16
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic [COEFF_WIDTH-1:0] weight_V_dout,
    input  logic                   weight_V_empty_n,
    output logic                   weight_V_read,
    input  logic [DATA_WIDTH-1:0]  input_V_dout,
    input  logic                   input_V_empty_n,
    output logic                   input_V_read,
    output logic [OUT_WIDTH-1:0]   output_V_din,
    input  logic                   output_V_full_n,
    output logic                   output_V_write
);

    localparam int c_cnt_w = (KERN_SIZE > 1) ? $clog2(KERN_SIZE) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(KERN_SIZE - 1);

    localparam logic [1:0] c_st_accum  = 2'd0;
    localparam logic [1:0] c_st_drain  = 2'd1;
    localparam logic [1:0] c_st_output = 2'd2;

    logic [1:0]                  r_state;
    logic [c_cnt_w-1:0]          r_count;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic signed [ACC_WIDTH-1:0] r_prod;
    logic                        r_prod_v;

    logic                        w_pop;
    logic                        w_accept;
    logic signed [ACC_WIDTH-1:0] w_coeff_ext;
    logic signed [ACC_WIDTH-1:0] w_data_ext;
    logic signed [ACC_WIDTH-1:0] w_prod;
    logic [OUT_WIDTH-1:0]        w_res;

    // Both FIFOs pop together so the weight/activation pairing never slips.
    assign w_pop    = (r_state == c_st_accum) & weight_V_empty_n & input_V_empty_n & ~ap_rst;
    assign w_accept = (r_state == c_st_output) & output_V_full_n;

    assign weight_V_read  = w_pop;
    assign input_V_read   = w_pop;
    assign output_V_write = w_accept;
    assign output_V_din   = w_res;

    assign w_coeff_ext = {{(ACC_WIDTH-COEFF_WIDTH){weight_V_dout[COEFF_WIDTH-1]}}, weight_V_dout};
    assign w_data_ext  = {{(ACC_WIDTH-DATA_WIDTH){input_V_dout[DATA_WIDTH-1]}}, input_V_dout};
    assign w_prod      = w_coeff_ext * w_data_ext;

`ifdef MAC_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] c_sat_max =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] c_sat_min = ~c_sat_max;

    logic signed [ACC_WIDTH-1:0] w_shifted;
    assign w_shifted = r_acc >>> OUT_SHIFT;

    always_comb begin
        w_res = w_shifted[OUT_WIDTH-1:0];
        if (w_shifted > c_sat_max) begin
            w_res = c_sat_max[OUT_WIDTH-1:0];
        end else if (w_shifted < c_sat_min) begin
            w_res = c_sat_min[OUT_WIDTH-1:0];
        end
    end
`else
    assign w_res = OUT_WIDTH'(r_acc >>> OUT_SHIFT);
`endif

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_state  <= c_st_accum;
            r_count  <= '0;
            r_acc    <= '0;
            r_prod   <= '0;
            r_prod_v <= 1'b0;
        end else begin
            r_prod_v <= w_pop;
            if (w_pop) begin
                r_prod <= w_prod;
            end

            case (r_state)
                c_st_accum: begin
                    if (w_pop) begin
                        if (r_count == c_last) begin
                            r_count <= '0;
                            r_state <= c_st_drain;
                        end else begin
                            r_count <= r_count + c_cnt_w'(1);
                        end
                    end
                end
                c_st_drain: begin
                    r_state <= c_st_output;
                end
                c_st_output: begin
                    if (output_V_full_n) begin
                        r_state <= c_st_accum;
                    end
                end
                default: begin
                    r_state <= c_st_accum;
                end
            endcase

            // The last product is still in flight during DRAIN and lands here.
            if (w_accept) begin
                r_acc <= '0;
            end else if (r_prod_v) begin
                r_acc <= r_acc + r_prod;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_mac_18.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_mac_18
// Brief    : Randomised bench for conv_mac_18 with a transaction-level model;
//            two instances (OUT_SHIFT=0 and default 8) share one stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_mac_18;

    localparam int K  = 9;
    localparam int AW = 40;
    localparam int OW = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] w_dout;
    logic        w_en;
    logic [15:0] a_dout;
    logic        a_en;
    logic        full_n;

    logic        rd0_w, rd0_a, wr0;
    logic        rd8_w, rd8_a, wr8;
    logic [15:0] din0, din8;

    always #5 clk = ~clk;

    conv_mac_18 #(.OUT_SHIFT(0)) u_dut0 (
        .ap_clk(clk), .ap_rst(rst),
        .weight_V_dout(w_dout), .weight_V_empty_n(w_en), .weight_V_read(rd0_w),
        .input_V_dout(a_dout), .input_V_empty_n(a_en), .input_V_read(rd0_a),
        .output_V_din(din0), .output_V_full_n(full_n), .output_V_write(wr0)
    );

    conv_mac_18 u_dut8 (
        .ap_clk(clk), .ap_rst(rst),
        .weight_V_dout(w_dout), .weight_V_empty_n(w_en), .weight_V_read(rd8_w),
        .input_V_dout(a_dout), .input_V_empty_n(a_en), .input_V_read(rd8_a),
        .output_V_din(din8), .output_V_full_n(full_n), .output_V_write(wr8)
    );

    int total = 0;
    int bad   = 0;

    int wq[$];
    int aq[$];
    int got0[$];
    int got8[$];

    // Transaction-level model state
    int     m_pops = 0;
    longint m_sum  = 0;
    longint m_ksum = 0;
    bit     m_gap  = 0;
    bit     m_outp = 0;
    bit     d_rd   = 0;
    bit     d_wr   = 0;
    int     d_w    = 0;
    int     d_a    = 0;

    int wmode = 0;
    int amode = 0;
    int fmode = 0;
    int stall_left = 0;
    bit tog = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int expect_res(input longint s, input int sh);
        logic signed [AW-1:0] a;
        logic signed [AW-1:0] r;
        a = s[AW-1:0];
        r = a >>> sh;
`ifdef MAC_SAT_EN
        if (r > 40'sd32767)  return 32767;
        if (r < -40'sd32768) return -32768;
        return int'(r);
`else
        return int'($signed(r[OW-1:0]));
`endif
    endfunction

    // Compare process: outputs are checked mid-cycle against the model.
    always @(negedge clk) begin
        if (rst) begin
            m_pops = 0; m_sum = 0; m_gap = 0; m_outp = 0; d_rd = 0; d_wr = 0;
            check("rst_rd0_w", int'(rd0_w), 0);
            check("rst_rd0_a", int'(rd0_a), 0);
            check("rst_wr0",   int'(wr0), 0);
            check("rst_din0",  int'(din0), 0);
            check("rst_rd8_w", int'(rd8_w), 0);
            check("rst_rd8_a", int'(rd8_a), 0);
            check("rst_wr8",   int'(wr8), 0);
            check("rst_din8",  int'(din8), 0);
        end else begin
            d_rd = !m_gap && !m_outp && w_en && a_en;
            d_wr = m_outp && full_n;
            check("rd0_w", int'(rd0_w), int'(d_rd));
            check("rd0_a", int'(rd0_a), int'(d_rd));
            check("rd8_w", int'(rd8_w), int'(d_rd));
            check("rd8_a", int'(rd8_a), int'(d_rd));
            check("wr0",   int'(wr0), int'(d_wr));
            check("wr8",   int'(wr8), int'(d_wr));
            if (m_outp) begin
                check("din0", int'($signed(din0)), expect_res(m_ksum, 0));
                check("din8", int'($signed(din8)), expect_res(m_ksum, 8));
            end
            if (wr0) got0.push_back(int'($signed(din0)));
            if (wr8) got8.push_back(int'($signed(din8)));
            if (d_rd) begin
                d_w = wq[0];
                d_a = aq[0];
            end
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            if (m_outp) begin
                if (d_wr) m_outp = 0;
            end else if (m_gap) begin
                m_gap  = 0;
                m_outp = 1;
            end else if (d_rd) begin
                void'(wq.pop_front());
                void'(aq.pop_front());
                m_sum += longint'(d_w) * longint'(d_a);
                m_pops++;
                if (m_pops == K) begin
                    m_ksum = m_sum;
                    m_sum  = 0;
                    m_pops = 0;
                    m_gap  = 1;
                end
            end
        end
    end

    task automatic drive();
        bit we;
        bit ae;
        case (wmode)
            0:       we = 1'b1;
            1:       we = tog;
            default: we = 1'($urandom_range(0, 1));
        endcase
        case (amode)
            0:       ae = 1'b1;
            1:       ae = tog;
            default: ae = 1'($urandom_range(0, 1));
        endcase
        tog = ~tog;
        w_en   = we && (wq.size() > 0);
        a_en   = ae && (aq.size() > 0);
        w_dout = w_en ? 16'(wq[0]) : 16'($urandom);
        a_dout = a_en ? 16'(aq[0]) : 16'($urandom);
        if (stall_left > 0 && m_outp) begin
            full_n = 1'b0;
            stall_left--;
        end else begin
            full_n = (fmode != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic push_k(input int w, input int a0, input int ainc);
        for (int i = 0; i < K; i++) begin
            wq.push_back(w);
            aq.push_back(a0 + i * ainc);
        end
    endtask

    task automatic get_result(input string name, output int r0, output int r8);
        r0 = 0;
        r8 = 0;
        for (int i = 0; i < 400 && (got0.size() == 0 || got8.size() == 0); i++) step();
        if (got0.size() == 0 || got8.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no write, expected one within 400 cycles", name);
        end else begin
            r0 = got0.pop_front();
            r8 = got8.pop_front();
        end
    endtask

    initial begin
        int r0;
        int r8;
        w_en = 0; a_en = 0; w_dout = '0; a_dout = '0; full_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive();

        // Pin the model arithmetic itself
        check("model_45",    expect_res(64'sd45, 0), 45);
        check("model_2304",  expect_res(64'sd589824, 8), 2304);

        // Ramp kernel, always ready
        push_k(1, 1, 1);
        get_result("t1", r0, r8);
        check("t1_sh0", r0, 45);
        check("t1_sh8", r8, 0);

        push_k(-2, 3, 0);
        get_result("t2a", r0, r8);
        check("t2a_sh0", r0, -54);

        push_k(256, 256, 0);
        get_result("t2b", r0, r8);
        check("t2b_sh8", r8, 2304);
`ifdef MAC_SAT_EN
        check("t2b_sh0", r0, 32767);
`else
        check("t2b_sh0", r0, 0);
`endif

        // Backpressure in OUTPUT
        stall_left = 5;
        push_k(1, 1, 1);
        get_result("t3", r0, r8);
        check("t3_sh0", r0, 45);
        check("t3_stall_used", stall_left, 0);

        // Starvation patterns
        wmode = 1; amode = 2;
        push_k(1, 1, 1);
        get_result("t4", r0, r8);
        check("t4_sh0", r0, 45);

        // Random kernels under random handshakes
        wmode = 2; amode = 2; fmode = 1;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < K; i++) begin
                wq.push_back(int'($urandom_range(0, 65535)) - 32768);
                aq.push_back(int'($urandom_range(0, 65535)) - 32768);
            end
            get_result("rand", r0, r8);
        end

        // Extreme magnitudes
        wmode = 0; amode = 0; fmode = 0;
        push_k(32767, 32767, 0);
        get_result("t5a", r0, r8);
`ifdef MAC_SAT_EN
        check("t5a_sh0", r0, 32767);
        check("t5a_sh8", r8, 32767);
`else
        check("t5a_sh0", r0, 9);
        check("t5a_sh8", r8, -2304);
`endif
        push_k(-32768, 32767, 0);
        get_result("t5b", r0, r8);
        check("t5b_sh0", r0, -32768);

        // Mid-kernel reset discards the partial sum
        for (int i = 0; i < 4; i++) begin
            wq.push_back(1000 + i);
            aq.push_back(-777 * (i + 1));
        end
        for (int i = 0; i < 50 && m_pops != 4; i++) step();
        check("t6_pops_before_rst", m_pops, 4);
        rst = 1'b1;
        wq.delete();
        aq.delete();
        drive();
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_k(1, 1, 1);
        drive();
        get_result("t6", r0, r8);
        check("t6_sh0", r0, 45);
        check("t6_sh8", r8, 0);

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
